// File: rtl/regfile_pkg.sv
// Shared constants and types for the pipelined-core register file.
package regfile_pkg;
  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 5;
  localparam int ZERO_REG   = 0;
  localparam int LINK_REG   = 31;

  typedef logic [ADDR_W_DEF-1:0] reg_addr_t;
endpackage

// File: rtl/reg_scoreboard.sv
// Per-register pending bits, pending counter and load-use stall for the issue stage.
module reg_scoreboard
  import regfile_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter bit BYPASS = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] ra1,
  input  logic [ADDR_W-1:0] ra2,
  input  logic              use1,
  input  logic              use2,
  input  logic              clr_a_en,
  input  logic [ADDR_W-1:0] clr_a_addr,
  input  logic              clr_b_en,
  input  logic [ADDR_W-1:0] clr_b_addr,
  input  logic              mark_en,
  input  logic [ADDR_W-1:0] mark_addr,
  output logic              stall,
  output logic [ADDR_W:0]   pend_cnt
);
  localparam int DEPTH = 2**ADDR_W;
  localparam logic [ADDR_W-1:0] ZA = ADDR_W'(ZERO_REG);

  logic [DEPTH-1:0] r_pend;
  logic [ADDR_W:0]  r_cnt;
  logic [DEPTH-1:0] w_pend_nxt;
  logic w_clr_a, w_clr_b, w_set;
  logic w_wr1, w_wr2, w_need1, w_need2;
  logic w_inc, w_dec_a, w_dec_b;

  assign w_clr_a = clr_a_en && (clr_a_addr != ZA);
  assign w_clr_b = clr_b_en && (clr_b_addr != ZA);
  assign w_set   = mark_en && !stall && (mark_addr != ZA);

  assign w_wr1 = (w_clr_a && clr_a_addr == ra1) || (w_clr_b && clr_b_addr == ra1);
  assign w_wr2 = (w_clr_a && clr_a_addr == ra2) || (w_clr_b && clr_b_addr == ra2);

  // A register being written this cycle only releases the stall when the value is forwarded.
  assign w_need1 = use1 && (ra1 != ZA) && r_pend[ra1] && !(BYPASS && w_wr1);
  assign w_need2 = use2 && (ra2 != ZA) && r_pend[ra2] && !(BYPASS && w_wr2);
  assign stall   = w_need1 || w_need2;

  // A new producer supersedes a retiring one, so set is applied after the clears.
  always_comb begin
    w_pend_nxt = r_pend;
    if (w_clr_a) w_pend_nxt[clr_a_addr] = 1'b0;
    if (w_clr_b) w_pend_nxt[clr_b_addr] = 1'b0;
    if (w_set)   w_pend_nxt[mark_addr]  = 1'b1;
    w_pend_nxt[ZA] = 1'b0;
  end

  assign w_inc   = w_set && !r_pend[mark_addr];
  assign w_dec_a = w_clr_a && r_pend[clr_a_addr] && !(w_set && mark_addr == clr_a_addr);
  assign w_dec_b = w_clr_b && r_pend[clr_b_addr] && !(w_set && mark_addr == clr_b_addr)
                   && !(w_clr_a && clr_a_addr == clr_b_addr);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pend <= '0;
      r_cnt  <= '0;
    end else begin
      r_pend <= w_pend_nxt;
      r_cnt  <= r_cnt + {{ADDR_W{1'b0}}, w_inc}
                      - {{ADDR_W{1'b0}}, w_dec_a}
                      - {{ADDR_W{1'b0}}, w_dec_b};
    end
  end

  assign pend_cnt = r_cnt;
endmodule

// File: rtl/reg_file_sb.sv
// Two-read / write-back + link-write register file with optional bypass and load-use scoreboard.
module reg_file_sb
#(
  parameter int DATA_W   = regfile_pkg::DATA_W_DEF,
  parameter int ADDR_W   = regfile_pkg::ADDR_W_DEF,
  parameter bit BYPASS   = 1'b1,
  parameter int LINK_REG = regfile_pkg::LINK_REG
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] ra1,
  input  logic [ADDR_W-1:0] ra2,
  output logic [DATA_W-1:0] rd1,
  output logic [DATA_W-1:0] rd2,
  input  logic              use1,
  input  logic              use2,
  input  logic              we,
  input  logic [ADDR_W-1:0] wa,
  input  logic [DATA_W-1:0] wd,
  input  logic              link_we,
  input  logic [DATA_W-1:0] link_wd,
  input  logic              mark_en,
  input  logic [ADDR_W-1:0] mark_addr,
  output logic              stall,
  output logic [ADDR_W:0]   pend_cnt
);
  import regfile_pkg::*;

  localparam int DEPTH = 2**ADDR_W;
  localparam logic [ADDR_W-1:0] ZA     = ADDR_W'(ZERO_REG);
  localparam logic [ADDR_W-1:0] LINK_A = ADDR_W'(LINK_REG);

  logic [DATA_W-1:0] r_regs [DEPTH];
  logic [DATA_W-1:0] w_rd1, w_rd2;
  logic              w_link_we;

  assign w_link_we = link_we && (LINK_A != ZA);

  // Link port is applied last so it wins a same-cycle collision on LINK_REG.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) r_regs[i] <= '0;
    end else begin
      if (we && wa != ZA) r_regs[wa]     <= wd;
      if (w_link_we)      r_regs[LINK_A] <= link_wd;
    end
  end

  always_comb begin
    w_rd1 = r_regs[ra1];
    w_rd2 = r_regs[ra2];
    if (BYPASS) begin
      if (we && wa == ra1)              w_rd1 = wd;
      if (w_link_we && ra1 == LINK_A)   w_rd1 = link_wd;
      if (we && wa == ra2)              w_rd2 = wd;
      if (w_link_we && ra2 == LINK_A)   w_rd2 = link_wd;
    end
    if (ra1 == ZA || !rst_n) w_rd1 = '0;
    if (ra2 == ZA || !rst_n) w_rd2 = '0;
  end

  assign rd1 = w_rd1;
  assign rd2 = w_rd2;

  reg_scoreboard #(
    .ADDR_W (ADDR_W),
    .BYPASS (BYPASS)
  ) u_sb (
    .clk        (clk),
    .rst_n      (rst_n),
    .ra1        (ra1),
    .ra2        (ra2),
    .use1       (use1),
    .use2       (use2),
    .clr_a_en   (we),
    .clr_a_addr (wa),
    .clr_b_en   (w_link_we),
    .clr_b_addr (LINK_A),
    .mark_en    (mark_en),
    .mark_addr  (mark_addr),
    .stall      (stall),
    .pend_cnt   (pend_cnt)
  );
endmodule

// File: tb/tb_reg_file_sb.sv
// Scoreboard-driven bench for reg_file_sb, with a BYPASS=1 and a BYPASS=0 instance sharing stimulus.
module tb_reg_file_sb;
  import regfile_pkg::*;

  logic        clk;
  logic        rst_n;
  reg_addr_t   ra1, ra2, wa, mark_addr;
  logic        use1, use2, we, link_we, mark_en;
  logic [31:0] wd, link_wd;
  logic [31:0] rd1, rd2, rd1_n, rd2_n;
  logic        stall, stall_n;
  logic [5:0]  pend_cnt, pend_cnt_n;

  int errors = 0;
  int checks = 0;

  localparam int S_RD1 = 0, S_RD2 = 1, S_STALL = 2, S_PEND = 3;
  localparam int S_RD1N = 4, S_RD2N = 5, S_STALLN = 6, S_PENDN = 7;

  typedef struct {
    string       nm;
    int          sel;
    logic [31:0] exp;
  } exp_t;
  exp_t q[$];
  exp_t e;

  reg_file_sb #(.DATA_W(32), .ADDR_W(5), .BYPASS(1'b1), .LINK_REG(31)) dut (
    .clk(clk), .rst_n(rst_n), .ra1(ra1), .ra2(ra2), .rd1(rd1), .rd2(rd2),
    .use1(use1), .use2(use2), .we(we), .wa(wa), .wd(wd),
    .link_we(link_we), .link_wd(link_wd), .mark_en(mark_en), .mark_addr(mark_addr),
    .stall(stall), .pend_cnt(pend_cnt)
  );

  reg_file_sb #(.DATA_W(32), .ADDR_W(5), .BYPASS(1'b0), .LINK_REG(31)) dut_nb (
    .clk(clk), .rst_n(rst_n), .ra1(ra1), .ra2(ra2), .rd1(rd1_n), .rd2(rd2_n),
    .use1(use1), .use2(use2), .we(we), .wa(wa), .wd(wd),
    .link_we(link_we), .link_wd(link_wd), .mark_en(mark_en), .mark_addr(mark_addr),
    .stall(stall_n), .pend_cnt(pend_cnt_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] obs(input int sel);
    case (sel)
      S_RD1:    return rd1;
      S_RD2:    return rd2;
      S_STALL:  return {31'b0, stall};
      S_PEND:   return 32'(pend_cnt);
      S_RD1N:   return rd1_n;
      S_RD2N:   return rd2_n;
      S_STALLN: return {31'b0, stall_n};
      default:  return 32'(pend_cnt_n);
    endcase
  endfunction

  task automatic idle();
    ra1 = '0; ra2 = '0; use1 = 1'b0; use2 = 1'b0;
    we = 1'b0; wa = '0; wd = '0;
    link_we = 1'b0; link_wd = '0;
    mark_en = 1'b0; mark_addr = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    idle(); we = 1'b1; wa = 5'd5; wd = 32'h1234; tick();
    idle(); mark_en = 1'b1; mark_addr = 5'd10; tick();
    idle(); ra1 = 5'd5; ra2 = 5'd10; use2 = 1'b1;
    q.push_back('{nm:"pre_rst rd1", sel:S_RD1, exp:32'h1234});
    q.push_back('{nm:"pre_rst rd1 nb", sel:S_RD1N, exp:32'h1234});
    q.push_back('{nm:"pre_rst stall", sel:S_STALL, exp:32'd1});
    q.push_back('{nm:"pre_rst pend", sel:S_PEND, exp:32'd1});
    @(negedge clk);
    while (q.size() > 0) begin
      e = q.pop_front(); checks++;
      if (obs(e.sel) !== e.exp) begin
        errors++; $display("FAIL %s: got %h expected %h", e.nm, obs(e.sel), e.exp);
      end
    end
    we = 1'b1; wa = 5'd6; wd = 32'hBEEF;
    #2 rst_n = 1'b0;
    #1;
    q.push_back('{nm:"rst rd1", sel:S_RD1, exp:32'h0});
    q.push_back('{nm:"rst rd1 nb", sel:S_RD1N, exp:32'h0});
    q.push_back('{nm:"rst stall", sel:S_STALL, exp:32'd0});
    q.push_back('{nm:"rst pend", sel:S_PEND, exp:32'd0});
    q.push_back('{nm:"rst pend nb", sel:S_PENDN, exp:32'd0});
    while (q.size() > 0) begin
      e = q.pop_front(); checks++;
      if (obs(e.sel) !== e.exp) begin
        errors++; $display("FAIL %s: got %h expected %h", e.nm, obs(e.sel), e.exp);
      end
    end
    tick();
    idle(); ra1 = 5'd6; ra2 = 5'd5;
    #2 rst_n = 1'b1;
    q.push_back('{nm:"rst discard rd1", sel:S_RD1, exp:32'h0});
    q.push_back('{nm:"rst cleared rd2", sel:S_RD2, exp:32'h0});
    q.push_back('{nm:"rst discard rd1 nb", sel:S_RD1N, exp:32'h0});
    @(negedge clk);
    while (q.size() > 0) begin
      e = q.pop_front(); checks++;
      if (obs(e.sel) !== e.exp) begin
        errors++; $display("FAIL %s: got %h expected %h", e.nm, obs(e.sel), e.exp);
      end
    end
    tick();
  endtask

  task automatic test_zero_reg();
    idle(); we = 1'b1; wa = 5'd0; wd = 32'hDEADBEEF; ra1 = 5'd0;
    q.push_back('{nm:"zero same cycle rd1", sel:S_RD1, exp:32'h0});
    @(negedge clk);
    while (q.size() > 0) begin
      e = q.pop_front(); checks++;
      if (obs(e.sel) !== e.exp) begin
        errors++; $display("FAIL %s: got %h expected %h", e.nm, obs(e.sel), e.exp);
      end
    end
    tick();
    idle(); ra1 = 5'd0; ra2 = 5'd0; mark_en = 1'b1; mark_addr = 5'd0;
    q.push_back('{nm:"zero rd1", sel:S_RD1, exp:32'h0});
    q.push_back('{nm:"zero rd2 nb", sel:S_RD2N, exp:32'h0});
    @(negedge clk);
    while (q.size() > 0) begin
      e = q.pop_front(); checks++;
      if (obs(e.sel) !== e.exp) begin
        errors++; $display("FAIL %s: got %h expected %h", e.nm, obs(e.sel), e.exp);
      end
    end
    tick();
    idle(); use1 = 1'b1; ra1 = 5'd0;
    q.push_back('{nm:"zero mark pend", sel:S_PEND, exp:32'd0});
    q.push_back('{nm:"zero no stall", sel:S_STALL, exp:32'd0});
    @(negedge clk);
    while (q.size() > 0) begin
      e = q.pop_front(); checks++;
      if (obs(e.sel) !== e.exp) begin
        errors++; $display("FAIL %s: got %h expected %h", e.nm, obs(e.sel), e.exp);
      end
    end
    tick();
  endtask

  task automatic test_bypass();
    idle(); we = 1'b1; wa = 5'd7; wd = 32'h11; tick();
    idle(); we = 1'b1; wa = 5'd7; wd = 32'hA5A5A5A5; ra2 = 5'd7;
    q.push_back('{nm:"bypass rd2", sel:S_RD2, exp:32'hA5A5A5A5});
    q.push_back('{nm:"nobypass rd2 old", sel:S_RD2N, exp:32'h11});
    @(negedge clk);
    while (q.size() > 0) begin
      e = q.pop_front(); checks++;
      if (obs(e.sel) !== e.exp) begin
        errors++; $display("FAIL %s: got %h expected %h", e.nm, obs(e.sel), e.exp);
      end
    end
    tick();
    idle(); ra2 = 5'd7;
    q.push_back('{nm:"bypass rd2 after", sel:S_RD2, exp:32'hA5A5A5A5});
    q.push_back('{nm:"nobypass rd2 after", sel:S_RD2N, exp:32'hA5A5A5A5});
    @(negedge clk);
    while (q.size() > 0) begin
      e = q.pop_front(); checks++;
      if (obs(e.sel) !== e.exp) begin
        errors++; $display("FAIL %s: got %h expected %h", e.nm, obs(e.sel), e.exp);
      end
    end
    tick();
  endtask

  task automatic test_load_use();
    idle(); mark_en = 1'b1; mark_addr = 5'd8; tick();
    idle(); use1 = 1'b1; ra1 = 5'd8;
    q.push_back('{nm:"lu pend", sel:S_PEND, exp:32'd1});
    q.push_back('{nm:"lu stall", sel:S_STALL, exp:32'd1});
    q.push_back('{nm:"lu stall nb", sel:S_STALLN, exp:32'd1});
    @(negedge clk);
    while (q.size() > 0) begin
      e = q.pop_front(); checks++;
      if (obs(e.sel) !== e.exp) begin
        errors++; $display("FAIL %s: got %h expected %h", e.nm, obs(e.sel), e.exp);
      end
    end
    tick();
    idle(); use1 = 1'b1; ra1 = 5'd8; we = 1'b1; wa = 5'd8; wd = 32'd42;
    q.push_back('{nm:"lu wb stall", sel:S_STALL, exp:32'd0});
    q.push_back('{nm:"lu wb rd1", sel:S_RD1, exp:32'd42});
    q.push_back('{nm:"lu wb stall nb", sel:S_STALLN, exp:32'd1});
    q.push_back('{nm:"lu wb rd1 nb", sel:S_RD1N, exp:32'd0});
    @(negedge clk);
    while (q.size() > 0) begin
      e = q.pop_front(); checks++;
      if (obs(e.sel) !== e.exp) begin
        errors++; $display("FAIL %s: got %h expected %h", e.nm, obs(e.sel), e.exp);
      end
    end
    tick();
    idle(); use1 = 1'b1; ra1 = 5'd8;
    q.push_back('{nm:"lu after pend", sel:S_PEND, exp:32'd0});
    q.push_back('{nm:"lu after pend nb", sel:S_PENDN, exp:32'd0});
    q.push_back('{nm:"lu after stall nb", sel:S_STALLN, exp:32'd0});
    q.push_back('{nm:"lu after rd1 nb", sel:S_RD1N, exp:32'd42});
    @(negedge clk);
    while (q.size() > 0) begin
      e = q.pop_front(); checks++;
      if (obs(e.sel) !== e.exp) begin
        errors++; $display("FAIL %s: got %h expected %h", e.nm, obs(e.sel), e.exp);
      end
    end
    tick();
  endtask

  task automatic test_collision();
    idle(); mark_en = 1'b1; mark_addr = 5'd9; tick();
    idle(); we = 1'b1; wa = 5'd9; wd = 32'd5; mark_en = 1'b1; mark_addr = 5'd9; tick();
    idle(); use1 = 1'b1; ra1 = 5'd9;
    q.push_back('{nm:"coll pend", sel:S_PEND, exp:32'd1});
    q.push_back('{nm:"coll still pending", sel:S_STALL, exp:32'd1});
    @(negedge clk);
    while (q.size() > 0) begin
      e = q.pop_front(); checks++;
      if (obs(e.sel) !== e.exp) begin
        errors++; $display("FAIL %s: got %h expected %h", e.nm, obs(e.sel), e.exp);
      end
    end
    mark_en = 1'b1; mark_addr = 5'd12;
    tick();
    idle(); use1 = 1'b1; ra1 = 5'd12;
    q.push_back('{nm:"mark under stall pend", sel:S_PEND, exp:32'd1});
    q.push_back('{nm:"mark under stall no bit", sel:S_STALL, exp:32'd0});
    @(negedge clk);
    while (q.size() > 0) begin
      e = q.pop_front(); checks++;
      if (obs(e.sel) !== e.exp) begin
        errors++; $display("FAIL %s: got %h expected %h", e.nm, obs(e.sel), e.exp);
      end
    end
    tick();
    idle(); we = 1'b1; wa = 5'd9; wd = 32'd6; tick();
    idle();
  endtask

  task automatic test_link();
    idle(); mark_en = 1'b1; mark_addr = 5'd20; tick();
    idle(); mark_en = 1'b1; mark_addr = 5'd31; tick();
    idle(); we = 1'b1; wa = 5'd31; wd = 32'h10; link_we = 1'b1; link_wd = 32'h40;
    ra1 = 5'd31; use1 = 1'b1;
    q.push_back('{nm:"link pend before", sel:S_PEND, exp:32'd2});
    q.push_back('{nm:"link bypass rd1", sel:S_RD1, exp:32'h40});
    q.push_back('{nm:"link rd1 nb old", sel:S_RD1N, exp:32'h0});
    q.push_back('{nm:"link stall", sel:S_STALL, exp:32'd0});
    q.push_back('{nm:"link stall nb", sel:S_STALLN, exp:32'd1});
    @(negedge clk);
    while (q.size() > 0) begin
      e = q.pop_front(); checks++;
      if (obs(e.sel) !== e.exp) begin
        errors++; $display("FAIL %s: got %h expected %h", e.nm, obs(e.sel), e.exp);
      end
    end
    tick();
    idle(); ra1 = 5'd31;
    q.push_back('{nm:"link stored", sel:S_RD1, exp:32'h40});
    q.push_back('{nm:"link stored nb", sel:S_RD1N, exp:32'h40});
    q.push_back('{nm:"link pend dec1", sel:S_PEND, exp:32'd1});
    q.push_back('{nm:"link pend dec1 nb", sel:S_PENDN, exp:32'd1});
    @(negedge clk);
    while (q.size() > 0) begin
      e = q.pop_front(); checks++;
      if (obs(e.sel) !== e.exp) begin
        errors++; $display("FAIL %s: got %h expected %h", e.nm, obs(e.sel), e.exp);
      end
    end
    tick();
    idle(); we = 1'b1; wa = 5'd20; wd = 32'd1; tick();
    idle();
  endtask

  function automatic reg_addr_t pick();
    int r;
    r = $urandom_range(0, 8);
    return (r == 8) ? reg_addr_t'(31) : reg_addr_t'(r);
  endfunction

  task automatic test_back_to_back();
    logic [31:0] m [32];
    bit          mp [32];
    bit          s_e, b1, b2;
    int          cnt;
    logic [31:0] x1, x2;
    idle();
    #2 rst_n = 1'b0;
    tick();
    #1 rst_n = 1'b1;
    for (int i = 0; i < 32; i++) begin m[i] = '0; mp[i] = 1'b0; end
    for (int c = 0; c < 60; c++) begin
      we = 1'($urandom_range(0, 1)); wa = pick(); wd = $urandom;
      link_we = ($urandom_range(0, 3) == 0); link_wd = $urandom;
      ra1 = pick(); ra2 = pick();
      use1 = 1'($urandom_range(0, 1)); use2 = 1'($urandom_range(0, 1));
      mark_en = ($urandom_range(0, 2) == 0); mark_addr = pick();
      x1 = (ra1 == 0) ? 32'h0 : (link_we && ra1 == 31) ? link_wd
         : (we && wa == ra1) ? wd : m[ra1];
      x2 = (ra2 == 0) ? 32'h0 : (link_we && ra2 == 31) ? link_wd
         : (we && wa == ra2) ? wd : m[ra2];
      b1 = (we && wa != 0 && wa == ra1) || (link_we && ra1 == 31);
      b2 = (we && wa != 0 && wa == ra2) || (link_we && ra2 == 31);
      s_e = (use1 && ra1 != 0 && mp[ra1] && !b1) || (use2 && ra2 != 0 && mp[ra2] && !b2);
      cnt = 0;
      for (int i = 0; i < 32; i++) cnt += int'(mp[i]);
      q.push_back('{nm:"b2b rd1", sel:S_RD1, exp:x1});
      q.push_back('{nm:"b2b rd2", sel:S_RD2, exp:x2});
      q.push_back('{nm:"b2b stall", sel:S_STALL, exp:{31'b0, s_e}});
      q.push_back('{nm:"b2b pend", sel:S_PEND, exp:32'(cnt)});
      @(negedge clk);
      while (q.size() > 0) begin
        e = q.pop_front(); checks++;
        if (obs(e.sel) !== e.exp) begin
          errors++; $display("FAIL %s cyc%0d: got %h expected %h", e.nm, c, obs(e.sel), e.exp);
        end
      end
      if (we && wa != 0) begin m[wa] = wd; mp[wa] = 1'b0; end
      if (link_we) begin m[31] = link_wd; mp[31] = 1'b0; end
      if (mark_en && !s_e && mark_addr != 0) mp[mark_addr] = 1'b1;
      tick();
    end
    idle();
  endtask

  initial begin
    idle();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    tick();
    test_reset();
    test_zero_reg();
    test_bypass();
    test_load_use();
    test_collision();
    test_link();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/reg_file_sb.md
Name: reg_file_sb

Overview:
- Parametrised register file for the pipelined core; replaces the fixed 32x32 single-write register file.
- Provides two read ports with optional write-to-read bypass, a main write-back port, and a dedicated link-write port for jal.
- Contains a per-register pending scoreboard that raises a load-use stall for the issue stage.
- Sits between decode/issue and write-back.

Parameters:
- DATA_W, 32, register data width.
- ADDR_W, 5, register address width; depth = 2**ADDR_W.
- BYPASS, 1, 1 = same-cycle write data is forwarded to the read ports; 0 = reads see stored values only.
- LINK_REG, 31, register written by the link port.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- ra1, ra2  in  ADDR_W  read addresses.
- rd1, rd2  out  DATA_W  read data (combinational).
- use1, use2  in  1  issuing instruction actually reads ra1 / ra2.
- we  in  1  main write enable.
- wa  in  ADDR_W  main write address.
- wd  in  DATA_W  main write data.
- link_we  in  1  link write enable; target is LINK_REG.
- link_wd  in  DATA_W  link write data (PC+4).
- mark_en  in  1  issuing instruction is a long-latency producer (load).
- mark_addr  in  ADDR_W  destination register of that producer.
- stall  out  1  issue must hold this cycle.
- pend_cnt  out  ADDR_W+1  number of registers currently pending.

Behaviour:
- Reset (rst_n low, asynchronous):
  - All registers clear to 0; all pending bits clear to 0; pend_cnt = 0.
  - stall = 0; rd1/rd2 read 0.
  - Reset asserted mid-operation discards any in-flight write or mark in that cycle.
- Register 0:
  - Always reads 0.
  - Writes to it are ignored.
  - It is never marked pending and never causes a stall.
- Reads:
  - Combinational, zero latency.
  - When BYPASS=1, the following priority applies for each port (ra != 0):
    1. link_we && ra==LINK_REG -> link_wd.
    2. Otherwise, we && wa==ra -> wd.
    3. Otherwise, the stored value.
  - When BYPASS=0, reads return the stored value only; a write becomes visible the cycle after the edge.
- Writes (posedge clk):
  - Main write: we && wa!=0 -> reg[wa] <= wd.
  - Link write: link_we -> reg[LINK_REG] <= link_wd.
  - When both ports target LINK_REG in the same cycle, the link port wins.
- Scoreboard:
  - Clear: a write to address a (either port, a != 0) clears pending[a].
  - Set: mark_en && !stall && mark_addr!=0 sets pending[mark_addr].
  - Same cycle, same address set and clear: set wins, i.e. a new producer supersedes the retiring one.
  - stall = (use1 && ra1!=0 && pending[ra1] && !byp1) || (use2 && ra2!=0 && pending[ra2] && !byp2).
    - byp_i = BYPASS && the register is being written this cycle.
    - With BYPASS=0, a pending register stalls until the cycle after its write.
  - stall depends only on current inputs and the pending state; it is combinational and has no state of its own.
- pend_cnt:
  - Increments by 1 when a bit transitions 0->1.
  - Decrements by 1 for each bit that transitions 1->0 (up to two per cycle: main and link ports).
  - Applies the net change per cycle.
  - Range is 0..2**ADDR_W-1, because register 0 is never pending; no wrap can occur.
- Marking an already-pending register leaves it pending; pend_cnt is unchanged.

Decomposition:
- Package regfile_pkg holds:
  - Default DATA_W/ADDR_W.
  - ZERO_REG = 0 and LINK_REG = 31 constants.
  - Register-address type reg_addr_t.
- Natural sub-module reg_scoreboard:
  - Owns the pending bits, the pend_cnt counter, and the stall equation.
  - Inputs: ra/use, the clear events, and mark.
- The top level holds the storage array and the bypass muxes.

Test Plan:
1. Reset: assert rst_n=0 mid-run after writing reg5=0x1234 -> rd1(ra1=5)=0, pend_cnt=0, stall=0 immediately, without waiting for a clock edge.
2. Zero register: we=1, wa=0, wd=0xDEADBEEF; next cycle ra1=0 -> rd1=0; mark_addr=0 with mark_en -> pend_cnt stays 0.
3. Bypass (BYPASS=1): same cycle we=1, wa=7, wd=0xA5A5A5A5, ra2=7 -> rd2=0xA5A5A5A5 in that cycle.
   - With BYPASS=0, the same stimulus gives rd2 = the old value; the new value appears the next cycle.
4. Load-use stall:
   - Cycle 0: mark_en=1, mark_addr=8 -> pend_cnt=1.
   - Cycle 1: use1=1, ra1=8 -> stall=1.
   - Cycle 2: we=1, wa=8, wd=42 -> stall=0 and rd1=42 (BYPASS=1); pend_cnt=0 next cycle.
5. Set/clear collision: reg 9 pending; same cycle we=1 to wa=9 and mark_en=1 with mark_addr=9 -> pending[9] remains 1, pend_cnt unchanged.
   - In a separate run, mark_en while stall=1 -> no new pending bit.
6. Link priority: same cycle we=1, wa=31, wd=0x10 and link_we=1, link_wd=0x40 -> rd(31) bypass=0x40; stored value after the edge is 0x40.
   - If reg 31 was pending, pend_cnt decrements by exactly 1.
